// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types and defaults for the data-memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   owner_e     : which requester owns the outstanding transaction
//   CNT_W       : width of the latency and starvation counters (covers 1..15)
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int CNT_W          = 4;
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/dmem_starve_ctr.sv
// -----------------------------------------------------------------------------
// dmem_starve_ctr
// Saturating count of consecutive arbitrations the debug port has lost.
// Ports:
//   clk   in  clock, rising edge
//   reset in  asynchronous active-low reset (count -> 0)
//   inc   in  debug port lost an arbitration this cycle
//   clr   in  debug port was granted this cycle (has priority over inc)
//   sat   out count has reached STARVE_MAX; debug port must win next time
// -----------------------------------------------------------------------------
module dmem_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CNT_W-1:0] cnt;

    assign sat = (cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous data-memory port between the pipeline MEM stage
// (port C) and a debug/loader port (port D). One transaction is outstanding
// at a time. C has fixed priority; D is forced through after STARVE_MAX
// consecutive lost arbitrations.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   c_rd/c_wr/c_addr/c_wdata/c_func3   pipeline request (held until c_rsp_valid)
//   c_rsp_valid, c_rdata       one-cycle pipeline response and read data
//   c_stall                    pipeline stall: request pending, no response yet
//   d_rd/d_wr/d_addr/d_wdata/d_func3   debug request (held until d_rsp_valid)
//   d_gnt                      debug request issued to memory this cycle
//   d_rsp_valid, d_rdata       one-cycle debug response and read data
//   mem_rd/mem_wr              one-cycle memory command strobes
//   mem_addr/mem_wdata/mem_func3 memory command fields (hold after issue)
//   mem_rdata                  memory read data, valid MEM_LAT cycles after cmd
//   err                        sticky: rd and wr seen high together on a port
//
// Timing: issue in cycle T (IDLE), read data captured at T+MEM_LAT,
// response strobe at T+MEM_LAT+1, next issue no earlier than T+MEM_LAT+2.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [2:0]        c_func3,
    output logic              c_rsp_valid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,

    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_func3,
    output logic              d_gnt,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err
);

    arb_state_e        state, state_nxt;
    owner_e            owner, owner_nxt;
    logic [CNT_W-1:0]  lat_cnt, lat_nxt;

    logic              c_req, d_req;
    logic              issue, win_d, capture;
    logic              starve_sat, starve_inc, starve_clr;

    logic              wr_p0, wr_p1;
    logic [ADDR_W-1:0] addr_p0, addr_p1;
    logic [DATA_W-1:0] wdata_p0, wdata_p1;
    logic [2:0]        func3_p0, func3_p1;

    assign c_req = c_rd | c_wr;
    assign d_req = d_rd | d_wr;

    // ---- FSM next state / arbitration --------------------------------------
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        lat_nxt   = lat_cnt;
        issue     = 1'b0;
        win_d     = 1'b0;
        capture   = 1'b0;

        unique case (state)
            IDLE: begin
                // Gating with reset keeps every strobe low while reset is held,
                // so the first arbitration lands on the first edge after release.
                if (reset && (c_req || d_req)) begin
                    issue     = 1'b1;
                    win_d     = d_req && (!c_req || starve_sat);
                    owner_nxt = win_d ? OWN_D : OWN_C;
                    lat_nxt   = CNT_W'(MEM_LAT);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                lat_nxt = lat_cnt - 1'b1;
                if (lat_cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner   <= OWN_C;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            lat_cnt <= lat_nxt;
        end
    end

    // ---- p0: winner's command, driven straight onto the memory port --------
    // rd and wr together are treated as a write.
    assign wr_p0    = win_d ? d_wr    : c_wr;
    assign addr_p0  = win_d ? d_addr  : c_addr;
    assign wdata_p0 = win_d ? d_wdata : c_wdata;
    assign func3_p0 = win_d ? d_func3 : c_func3;

    assign mem_rd    = issue & ~wr_p0;
    assign mem_wr    = issue &  wr_p0;
    assign mem_addr  = issue ? addr_p0  : addr_p1;
    assign mem_wdata = issue ? wdata_p0 : wdata_p1;
    assign mem_func3 = issue ? func3_p0 : func3_p1;
    assign d_gnt     = issue & win_d;

    // ---- p1: command held for the rest of the transaction ------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            func3_p1 <= '0;
        end else if (issue) begin
            wr_p1    <= wr_p0;
            addr_p1  <= addr_p0;
            wdata_p1 <= wdata_p0;
            func3_p1 <= func3_p0;
        end
    end

    // ---- read-data capture into the owner's register -----------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_rdata <= '0;
            d_rdata <= '0;
        end else if (capture && !wr_p1) begin
            if (owner == OWN_C) begin
                c_rdata <= mem_rdata;
            end else begin
                d_rdata <= mem_rdata;
            end
        end
    end

    // ---- response / stall --------------------------------------------------
    assign c_rsp_valid = (state == RESP) && (owner == OWN_C);
    assign d_rsp_valid = (state == RESP) && (owner == OWN_D);
    // Stall follows C's own request regardless of who owns the memory.
    assign c_stall     = reset & c_req & ~c_rsp_valid;

    // ---- starvation guard --------------------------------------------------
    assign starve_inc = issue & d_req & ~win_d;
    assign starve_clr = issue & win_d;

    dmem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

    // ---- sticky protocol error ---------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((c_rd && c_wr) || (d_rd && d_wr)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Bench for dmem_arbiter: a cycle-by-cycle vector table on a MEM_LAT=1
// instance, a latency sequence on a MEM_LAT=3 instance, and a two-requester
// scoreboard run checking read data and the 4:1 starvation grant pattern.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // MEM_LAT=1 instance
    logic        c_rd, c_wr, d_rd, d_wr;
    logic [8:0]  c_addr, d_addr;
    logic [31:0] c_wdata, d_wdata;
    logic [2:0]  c_func3, d_func3;
    logic        c_rsp_valid, c_stall, d_gnt, d_rsp_valid;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_rd, mem_wr, err;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;

    // MEM_LAT=3 instance (C side only)
    logic        l3_c_rd;
    logic [8:0]  l3_c_addr;
    logic        l3_c_rsp_valid, l3_c_stall, l3_d_gnt, l3_d_rsp_valid;
    logic [31:0] l3_c_rdata, l3_d_rdata;
    logic        l3_mem_rd, l3_mem_wr, l3_err;
    logic [8:0]  l3_mem_addr;
    logic [31:0] l3_mem_wdata, l3_mem_rdata;
    logic [2:0]  l3_mem_func3;

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3),
        .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata), .c_stall(c_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
        .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata), .err(err)
    );

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_l3 (
        .clk(clk), .reset(reset),
        .c_rd(l3_c_rd), .c_wr(1'b0), .c_addr(l3_c_addr), .c_wdata(32'h0), .c_func3(3'b100),
        .c_rsp_valid(l3_c_rsp_valid), .c_rdata(l3_c_rdata), .c_stall(l3_c_stall),
        .d_rd(1'b0), .d_wr(1'b0), .d_addr(9'h0), .d_wdata(32'h0), .d_func3(3'b000),
        .d_gnt(l3_d_gnt), .d_rsp_valid(l3_d_rsp_valid), .d_rdata(l3_d_rdata),
        .mem_rd(l3_mem_rd), .mem_wr(l3_mem_wr), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
        .mem_func3(l3_mem_func3), .mem_rdata(l3_mem_rdata), .err(l3_err)
    );

    // ---- memory models (word array shared by both instances) ----------------
    logic [31:0] mem [0:127];
    logic [31:0] rd1;
    logic [31:0] l3_pipe [0:2];

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;
        if (mem_rd) rd1 <= mem[mem_addr[8:2]];
        l3_pipe[0] <= l3_mem_rd ? mem[l3_mem_addr[8:2]] : 32'h0;
        l3_pipe[1] <= l3_pipe[0];
        l3_pipe[2] <= l3_pipe[1];
    end
    assign mem_rdata    = rd1;
    assign l3_mem_rdata = l3_pipe[2];

    // ---- bookkeeping --------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---- scoreboard ---------------------------------------------------------
    logic [31:0] c_q [$];
    logic [31:0] d_q [$];
    logic        grants [$];
    logic        sb_on = 1'b0;

    always @(negedge clk) begin
        if (sb_on) begin
            if (mem_rd || mem_wr) grants.push_back(d_gnt);
            if (c_rsp_valid) begin
                if (c_q.size() == 0) fail("c_sb unexpected response");
                else check("c_sb_rdata", c_rdata, c_q.pop_front());
            end
            if (d_rsp_valid) begin
                if (d_q.size() == 0) fail("d_sb unexpected response");
                else check("d_sb_rdata", d_rdata, d_q.pop_front());
            end
        end
    end

    task automatic c_thread(input int n);
        for (int i = 0; i < n; i++) begin
            int  idx;
            bit  got;
            @(posedge clk); #1;
            idx    = $urandom_range(0, 127);
            c_rd   = 1'b1;
            c_addr = 9'(idx * 4);
            c_q.push_back(mem[idx]);
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (c_rsp_valid) got = 1'b1;
            end
            if (!got) fail("c_thread response timeout");
        end
        @(posedge clk); #1;
        c_rd = 1'b0;
    endtask

    task automatic d_thread(input int n);
        for (int i = 0; i < n; i++) begin
            int  idx;
            bit  got;
            @(posedge clk); #1;
            idx    = $urandom_range(0, 127);
            d_rd   = 1'b1;
            d_addr = 9'(idx * 4);
            d_q.push_back(mem[idx]);
            got = 1'b0;
            for (int k = 0; k < 80 && !got; k++) begin
                @(negedge clk);
                if (d_rsp_valid) got = 1'b1;
            end
            if (!got) fail("d_thread response timeout");
        end
        @(posedge clk); #1;
        d_rd = 1'b0;
    endtask

    // ---- vector table -------------------------------------------------------
    // flags = {mem_rd, mem_wr, c_stall, c_rsp_valid, d_gnt, d_rsp_valid, err}
    typedef struct {
        logic        rst;
        logic        c_rd;
        logic        c_wr;
        logic [8:0]  c_addr;
        logic [31:0] c_wdata;
        logic        d_rd;
        logic        d_wr;
        logic [8:0]  d_addr;
        logic [31:0] d_wdata;
        logic [6:0]  flags;
        logic [8:0]  e_addr;
        logic [31:0] e_crd;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic rst, input logic crd, input logic cwr, input logic [8:0] ca,
                       input logic [31:0] cwd, input logic drd, input logic dwr, input logic [8:0] da,
                       input logic [31:0] dwd, input logic [6:0] fl, input logic [8:0] ea,
                       input logic [31:0] ecr, input logic [31:0] edr);
        vec_t v;
        v.rst = rst; v.c_rd = crd; v.c_wr = cwr; v.c_addr = ca; v.c_wdata = cwd;
        v.d_rd = drd; v.d_wr = dwr; v.d_addr = da; v.d_wdata = dwd;
        v.flags = fl; v.e_addr = ea; v.e_crd = ecr; v.e_drd = edr;
        tbl.push_back(v);
    endtask

    localparam logic [31:0] BEEF = 32'hDEADBEEF;
    localparam logic [31:0] W1FC = 32'h12345678;
    localparam logic [31:0] WA5  = 32'hA5A5A5A5;

    logic [3:0] l3_exp [0:4];

    initial begin
        for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + 32'(i) * 32'h0001_0203;
        mem[4] <= BEEF;

        reset = 1'b0;
        c_rd = 0; c_wr = 0; c_addr = '0; c_wdata = '0; c_func3 = 3'b100;
        d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0; d_func3 = 3'b010;
        l3_c_rd = 0; l3_c_addr = '0;

        //   rst crd cwr caddr   cwdata  drd dwr daddr   dwdata  flags        eaddr  c_rdata d_rdata
        add(0, 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000000, 9'h000, 32'h0, 32'h0);
        add(0, 1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000000, 9'h000, 32'h0, 32'h0);
        add(1, 1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0, 7'b1010000, 9'h010, 32'h0, 32'h0);
        add(1, 1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0010000, 9'h010, 32'h0, 32'h0);
        add(1, 1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0001000, 9'h010, BEEF,  32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000000, 9'h010, BEEF,  32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 0, 1, 9'h1FC, W1FC,  7'b0100100, 9'h1FC, BEEF,  32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 0, 1, 9'h1FC, W1FC,  7'b0000000, 9'h1FC, BEEF,  32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 0, 1, 9'h1FC, W1FC,  7'b0000010, 9'h1FC, BEEF,  32'h0);
        add(1, 1, 0, 9'h1FC, 32'h0, 0, 0, 9'h000, 32'h0, 7'b1010000, 9'h1FC, BEEF,  32'h0);
        add(1, 1, 0, 9'h1FC, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0010000, 9'h1FC, BEEF,  32'h0);
        add(1, 1, 0, 9'h1FC, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0001000, 9'h1FC, W1FC,  32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 1, 0, 9'h010, 32'h0, 7'b1000100, 9'h010, W1FC,  32'h0);
        add(1, 1, 0, 9'h1FC, 32'h0, 1, 0, 9'h010, 32'h0, 7'b0010000, 9'h010, W1FC,  32'h0);
        add(1, 1, 0, 9'h1FC, 32'h0, 1, 0, 9'h010, 32'h0, 7'b0010010, 9'h010, W1FC,  BEEF);
        add(1, 1, 0, 9'h1FC, 32'h0, 0, 0, 9'h000, 32'h0, 7'b1010000, 9'h1FC, W1FC,  BEEF);
        add(1, 1, 0, 9'h1FC, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0010000, 9'h1FC, W1FC,  BEEF);
        add(1, 1, 0, 9'h1FC, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0001000, 9'h1FC, W1FC,  BEEF);
        add(1, 1, 1, 9'h020, WA5,   0, 0, 9'h000, 32'h0, 7'b0110000, 9'h020, W1FC,  BEEF);
        add(1, 1, 1, 9'h020, WA5,   0, 0, 9'h000, 32'h0, 7'b0010001, 9'h020, W1FC,  BEEF);
        add(1, 1, 1, 9'h020, WA5,   0, 0, 9'h000, 32'h0, 7'b0001001, 9'h020, W1FC,  BEEF);
        add(1, 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000001, 9'h020, W1FC,  BEEF);
        add(0, 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000000, 9'h000, 32'h0, 32'h0);
        add(1, 1, 0, 9'h020, 32'h0, 0, 0, 9'h000, 32'h0, 7'b1010000, 9'h020, 32'h0, 32'h0);
        add(1, 1, 0, 9'h020, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0010000, 9'h020, 32'h0, 32'h0);
        add(1, 1, 0, 9'h020, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0001000, 9'h020, WA5,   32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000000, 9'h020, WA5,   32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 1, 0, 9'h010, 32'h0, 7'b1000100, 9'h010, WA5,   32'h0);
        add(0, 0, 0, 9'h000, 32'h0, 1, 0, 9'h010, 32'h0, 7'b0000000, 9'h000, 32'h0, 32'h0);
        add(0, 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000000, 9'h000, 32'h0, 32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000000, 9'h000, 32'h0, 32'h0);
        add(1, 1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0, 7'b1010000, 9'h010, 32'h0, 32'h0);
        add(1, 1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0010000, 9'h010, 32'h0, 32'h0);
        add(1, 1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0001000, 9'h010, BEEF,  32'h0);
        add(1, 0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0, 7'b0000000, 9'h010, BEEF,  32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            @(posedge clk); #1;
            reset = v.rst;
            c_rd = v.c_rd; c_wr = v.c_wr; c_addr = v.c_addr; c_wdata = v.c_wdata;
            d_rd = v.d_rd; d_wr = v.d_wr; d_addr = v.d_addr; d_wdata = v.d_wdata;
            @(negedge clk);
            check($sformatf("vec%0d flags", i),
                  32'({mem_rd, mem_wr, c_stall, c_rsp_valid, d_gnt, d_rsp_valid, err}), 32'(v.flags));
            check($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(v.e_addr));
            check($sformatf("vec%0d c_rdata", i), c_rdata, v.e_crd);
            check($sformatf("vec%0d d_rdata", i), d_rdata, v.e_drd);
            if (v.flags[6] || v.flags[5])
                check($sformatf("vec%0d mem_func3", i), 32'(mem_func3),
                      v.flags[2] ? 32'(3'b010) : 32'(3'b100));
            if (v.flags[5])
                check($sformatf("vec%0d mem_wdata", i), mem_wdata,
                      v.flags[2] ? v.d_wdata : v.c_wdata);
        end

        // MEM_LAT=3: {mem_rd, mem_wr, c_stall, c_rsp_valid} over T..T+4
        l3_exp[0] = 4'b1010;
        l3_exp[1] = 4'b0010;
        l3_exp[2] = 4'b0010;
        l3_exp[3] = 4'b0010;
        l3_exp[4] = 4'b0001;
        @(posedge clk); #1;
        l3_c_rd   = 1'b1;
        l3_c_addr = 9'h010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("lat3 T+%0d flags", k),
                  32'({l3_mem_rd, l3_mem_wr, l3_c_stall, l3_c_rsp_valid}), 32'(l3_exp[k]));
            check($sformatf("lat3 T+%0d c_rdata", k), l3_c_rdata, (k == 4) ? BEEF : 32'h0);
            check($sformatf("lat3 T+%0d d_side", k),
                  32'({l3_d_gnt, l3_d_rsp_valid, l3_err}), 32'h0);
            if (k == 0) check("lat3 mem_func3", 32'(l3_mem_func3), 32'(3'b100));
        end
        @(posedge clk); #1;
        l3_c_rd = 1'b0;

        // Both ports reading back-to-back: expect C,C,C,C,D repeating
        @(posedge clk); #1;
        sb_on = 1'b1;
        fork
            c_thread(16);
            d_thread(4);
        join
        @(negedge clk);
        sb_on = 1'b0;
        check("sb c_q drained", 32'(c_q.size()), 32'd0);
        check("sb d_q drained", 32'(d_q.size()), 32'd0);
        check("grant count", 32'(grants.size()), 32'd20);
        for (int i = 0; i < grants.size() && i < 20; i++)
            check($sformatf("grant%0d is_d", i), 32'(grants[i]), 32'((i % 5) == 4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single synchronous data memory port (9-bit byte address, 32-bit data, func3 size/sign control) between two requesters: the pipeline MEM stage (port C) and a debug/loader port (port D).
- One transaction is outstanding at a time.
- The pipeline has fixed priority, with a starvation guard for the debug port.
- The block issues the memory command, waits the memory latency, captures read data, returns a one-cycle response to the owner, and generates the pipeline stall.

Parameters:
- ADDR_W, 9, data memory address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from command to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive lost IDLE-cycle arbitrations before the debug port is forced to win; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_rd  in  1  pipeline read request
- c_wr  in  1  pipeline write request
- c_addr  in  ADDR_W  pipeline address
- c_wdata  in  DATA_W  pipeline write data
- c_func3  in  3  pipeline access size/sign
- c_rsp_valid  out  1  pipeline response strobe, one cycle
- c_rdata  out  DATA_W  pipeline read data, valid with c_rsp_valid
- c_stall  out  1  pipeline stall request
- d_rd  in  1  debug read request
- d_wr  in  1  debug write request
- d_addr  in  ADDR_W  debug address
- d_wdata  in  DATA_W  debug write data
- d_func3  in  3  debug access size/sign
- d_gnt  out  1  debug request accepted this cycle
- d_rsp_valid  out  1  debug response strobe, one cycle
- d_rdata  out  DATA_W  debug read data
- mem_rd  out  1  memory read strobe, one cycle
- mem_wr  out  1  memory write strobe, one cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_func3  out  3  memory func3
- mem_rdata  in  DATA_W  memory read data
- err  out  1  sticky protocol error

Behaviour:
- States: IDLE, WAIT, RESP. Owner register: C or D.
- Requests:
  - A port requests when its rd or wr input is high.
  - Requests must be held stable until that port's rsp_valid.
- Arbitration in IDLE (combinational):
  - If only one port requests, it wins.
  - If both request, C wins unless starve_cnt == STARVE_MAX; then D wins.
- Issue cycle T (IDLE):
  - Winner's address, data and func3 drive the mem_* outputs.
  - mem_rd or mem_wr is asserted for cycle T only.
  - If D wins, d_gnt = 1.
  - Owner is latched; lat_cnt is loaded with MEM_LAT; next state is WAIT.
- WAIT:
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt == 1, mem_rdata is captured into the owner's rdata register; next state is RESP.
- RESP (cycle T+MEM_LAT+1):
  - Owner's rsp_valid = 1 for exactly one cycle; next state is IDLE.
  - Writes also produce rsp_valid; the rdata register is unchanged on writes.
- Latency: issue-to-response is MEM_LAT+1 cycles. A new issue is possible at T+MEM_LAT+2 at the earliest. No issue is allowed in WAIT or RESP.
- Stall rule: c_stall = (c_rd | c_wr) & ~c_rsp_valid. This applies in every state, including while D owns the memory.
- Starvation counter (starve_cnt, saturating):
  - Increments on each IDLE cycle where d requests and C wins.
  - Clears when D is granted.
  - Holds in WAIT and RESP.
- rd and wr both high on one port: treated as a write; err is set and stays set until reset.
- Outputs outside the issue cycle: mem_rd and mem_wr are 0. mem_addr, mem_wdata and mem_func3 hold their last driven value (registered).
- Reset (asserted low, asynchronous; may occur mid-transaction):
  - State returns to IDLE and the outstanding transaction is dropped.
  - Registers reset: starve_cnt 0, lat_cnt 0, owner C, err 0.
  - Outputs reset: all strobes 0, c_stall 0, c_rdata 0, d_rdata 0, mem_addr 0, mem_wdata 0, mem_func3 0.
  - After release, a request is first arbitrated on the first rising edge with reset high.

Decomposition:
- Shared package: arb_state_e enum (IDLE, WAIT, RESP), owner typedef (OWN_C, OWN_D), defaults for MEM_LAT and STARVE_MAX.
- Sub-module dmem_starve_ctr: saturating counter with inc/clr/sat outputs, parameterised by STARVE_MAX.

Test Plan:
- Reset release, C read at addr 0x010 with MEM_LAT=1, memory returns 0xDEADBEEF -> mem_rd high at cycle T only; c_rsp_valid and c_rdata=0xDEADBEEF at T+2; c_stall high T..T+1, low at T+2.
- Both ports read continuously with STARVE_MAX=4 -> C granted 4 times, then d_gnt on the 5th arbitration; starve_cnt clears; pattern repeats 4:1.
- D write to 0x1FC, data 0x12345678, func3=010, while C idle, then C read at 0x1FC -> mem_wr one cycle with matching fields; d_rsp_valid at T+2; C read returns 0x12345678 (memory model); c_stall high during D's transaction only when C requests.
- MEM_LAT=3, C read -> mem_rd at T, capture at T+3, c_rsp_valid at T+4; no mem strobe T+1..T+4.
- Reset asserted low during WAIT of a D read -> immediate IDLE, no d_rsp_valid, all outputs at reset values; a post-reset C request is issued normally.
- c_rd and c_wr both high -> write issued (mem_wr=1, mem_rd=0); err=1 and remains 1 until reset.
